// File: rtl/regfile_sb_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_sb_pkg;
    localparam int N_DEF    = 16;
    localparam int R_DEF    = 3;
    localparam int NR_DEF   = 2;
    localparam int ZERO_REG = 0;

    typedef logic [R_DEF-1:0] reg_addr_t;
    typedef logic [N_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits: an issue sets a bit, a writeback clears it.
// An issue wins over a writeback to the same register; entry 0 never goes busy.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int R = R_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [R-1:0]    iss_rd,
    input  logic            we,
    input  logic [R-1:0]    wa,
    output logic [(1<<R)-1:0] busy_vec
);
    localparam int D = 1 << R;

    logic [D-1:0] r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int i = 1; i < D; i++) begin
                if (iss_valid && iss_rd == R'(i))
                    r_busy[i] <= 1'b1;
                else if (we && wa == R'(i))
                    r_busy[i] <= 1'b0;
            end
        end
    end

    assign busy_vec = r_busy;
endmodule

// File: rtl/regfile_sb.sv
// N-bit x 2**R register file, NR combinational read ports, one write port, busy scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward the same-cycle writeback onto matching read ports.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int R  = R_DEF,
    parameter int NR = NR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [R-1:0]      wa,
    input  logic [N-1:0]      wd,
    input  logic [NR*R-1:0]   ra,
    output logic [NR*N-1:0]   rd,
    output logic [NR-1:0]     rd_busy,
    input  logic              iss_valid,
    input  logic [R-1:0]      iss_rd,
    output logic              hazard,
    output logic [(1<<R)-1:0] busy_vec
);
    localparam int D = 1 << R;

    logic [N-1:0] r_rf [D];
    logic [D-1:0] w_busy;
    logic [R-1:0] w_ra [NR];
    logic [NR-1:0] w_fwd;

    // Entry 0 is only ever written by reset, so it reads back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++)
                r_rf[i] <= '0;
        end else if (we && wa != R'(ZERO_REG)) begin
            r_rf[wa] <= wd;
        end
    end

    regfile_sb_scoreboard #(.R(R)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .we        (we),
        .wa        (wa),
        .busy_vec  (w_busy)
    );

    genvar k;
    for (k = 0; k < NR; k++) begin : g_rd
        assign w_ra[k] = ra[k*R +: R];
`ifdef REGFILE_SB_BYPASS_EN
        assign w_fwd[k] = we && (wa != R'(ZERO_REG)) && (w_ra[k] == wa);
`else
        assign w_fwd[k] = 1'b0;
`endif
        assign rd[k*N +: N] = (w_ra[k] == R'(ZERO_REG)) ? '0 :
                              (w_fwd[k] ? wd : r_rf[w_ra[k]]);
        // A forwarded value is by definition ready, even if issue re-marks it.
        assign rd_busy[k] = w_busy[w_ra[k]] & ~w_fwd[k];
    end

    assign hazard   = |rd_busy;
    assign busy_vec = w_busy;
endmodule
